// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks in-flight destination registers of the 5-stage pipeline and freezes
// IF/ID while a source operand's producer has not yet reached a forwardable
// stage. It covers load-use and multi-cycle (mul/div) results that the EX
// bypass network cannot cover.
//
// Optional build macro: SCOREBOARD_STATS_EN (adds stall statistics counters).
//
// Ports:
//   clk_i              clock
//   rst_i              synchronous reset, active-high
//   issue_valid_i      instruction leaving ID into EX this cycle
//   issue_wen_i        that instruction writes the register file
//   issue_rd_i         its destination register
//   issue_lat_i        cycles until its result is forwardable (0 ALU, 1 load)
//   id_rs1_i/id_rs2_i  source registers of the instruction in ID
//   id_use_rs1_i/2_i   ID instruction reads rs1 / rs2
//   wb_valid_i         register-file write this cycle
//   wb_rd_i            writeback destination
//   flush_i            branch flush; cancels this cycle's issue
//   stall_o            hold PC and IF/ID, bubble into ID/EX (combinational)
//   busy_o             per-register busy vector
//   pending_cnt_o      registered popcount of busy_o
//   stall_cycles_o     (stats) cycles with stall_o high, saturating
//   raw_stall_cycles_o (stats) cycles with a RAW hazard, saturating
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned LAT_W    = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    input  logic                issue_wen_i,
    input  logic [4:0]          issue_rd_i,
    input  logic [LAT_W-1:0]    issue_lat_i,
    input  logic [4:0]          id_rs1_i,
    input  logic [4:0]          id_rs2_i,
    input  logic                id_use_rs1_i,
    input  logic                id_use_rs2_i,
    input  logic                wb_valid_i,
    input  logic [4:0]          wb_rd_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] busy_o,
`ifdef SCOREBOARD_STATS_EN
    output logic [31:0]         stall_cycles_o,
    output logic [31:0]         raw_stall_cycles_o,
`endif
    output logic [5:0]          pending_cnt_o
);

    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 6;

    logic [NUM_REGS-1:0] r_busy;
    logic [LAT_W-1:0]    r_cnt [NUM_REGS];
    logic [CNT_W-1:0]    r_pending;

    logic                w_raw_rs1;
    logic                w_raw_rs2;
    logic                w_raw;
    logic                w_waw;
    logic                w_stall;
    logic                w_issue_acc;
    logic                w_wb_en;
    logic [CNT_W-1:0]    w_popcount;

    // Hazard detection: a busy entry with cnt==0 is covered by forwarding.
    always_comb begin
        w_raw_rs1 = id_use_rs1_i && (id_rs1_i != '0) && r_busy[id_rs1_i]
                    && (r_cnt[id_rs1_i] != '0);
        w_raw_rs2 = id_use_rs2_i && (id_rs2_i != '0) && r_busy[id_rs2_i]
                    && (r_cnt[id_rs2_i] != '0);
        w_raw     = w_raw_rs1 || w_raw_rs2;
        // Keep a short op from overtaking a longer one to the same rd.
        w_waw     = issue_valid_i && issue_wen_i && (issue_rd_i != '0)
                    && r_busy[issue_rd_i] && (r_cnt[issue_rd_i] > issue_lat_i);
        w_stall   = w_raw || w_waw;
        w_issue_acc = issue_valid_i && issue_wen_i && (issue_rd_i != '0)
                      && !flush_i && !w_stall;
        w_wb_en   = wb_valid_i && (wb_rd_i != '0);
    end

    // Number of busy entries, registered below.
    always_comb begin
        w_popcount = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_popcount = w_popcount + CNT_W'(r_busy[RD_W'(r)]);
        end
    end

    // Entry update: issue beats writeback beats countdown.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy    <= '0;
            r_pending <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_cnt[RD_W'(r)] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (w_issue_acc && (issue_rd_i == RD_W'(r))) begin
                    r_busy[RD_W'(r)] <= 1'b1;
                    r_cnt[RD_W'(r)]  <= issue_lat_i;
                end else if (w_wb_en && (wb_rd_i == RD_W'(r))) begin
                    r_busy[RD_W'(r)] <= 1'b0;
                    r_cnt[RD_W'(r)]  <= '0;
                end else if (r_busy[RD_W'(r)] && (r_cnt[RD_W'(r)] != '0)) begin
                    r_cnt[RD_W'(r)]  <= r_cnt[RD_W'(r)] - LAT_W'(1);
                end
            end
            r_busy[0] <= 1'b0;
            r_cnt[0]  <= '0;
            r_pending <= w_popcount;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_raw_stall_cycles;

    // Saturating stall statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cycles     <= '0;
            r_raw_stall_cycles <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'(1);
            end
            if (w_raw && (r_raw_stall_cycles != '1)) begin
                r_raw_stall_cycles <= r_raw_stall_cycles + 32'(1);
            end
        end
    end

    assign stall_cycles_o     = r_stall_cycles;
    assign raw_stall_cycles_o = r_raw_stall_cycles;
`endif

    assign stall_o       = w_stall;
    assign busy_o        = r_busy;
    assign pending_cnt_o = r_pending;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic compared against a behavioural model of the register hazards.
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_wen_i;
    logic [4:0]  issue_rd_i;
    logic [2:0]  issue_lat_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_use_rs1_i;
    logic        id_use_rs2_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] busy_o;
    logic [5:0]  pending_cnt_o;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] raw_stall_cycles_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: remaining cycles until each register's value can be forwarded.
    bit          m_busy [32];
    int          m_left [32];
    int          m_pend;
    int unsigned m_stall_cyc;
    int unsigned m_raw_cyc;

    hazard_scoreboard dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_wen_i(issue_wen_i),
        .issue_rd_i(issue_rd_i), .issue_lat_i(issue_lat_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .busy_o(busy_o),
`ifdef SCOREBOARD_STATS_EN
        .stall_cycles_o(stall_cycles_o),
        .raw_stall_cycles_o(raw_stall_cycles_o),
`endif
        .pending_cnt_o(pending_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit src_waiting(int r, bit used);
        return used && r != 0 && m_busy[r] && m_left[r] > 0;
    endfunction

    function automatic bit m_raw();
        return src_waiting(int'(id_rs1_i), id_use_rs1_i) ||
               src_waiting(int'(id_rs2_i), id_use_rs2_i);
    endfunction

    function automatic bit m_stall();
        int rd = int'(issue_rd_i);
        bit waw = issue_valid_i && issue_wen_i && rd != 0 && m_busy[rd]
                  && m_left[rd] > int'(issue_lat_i);
        return m_raw() || waw;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit acc;
        int cnt = 0;
        for (int r = 0; r < 32; r++) cnt += int'(m_busy[r]);
        acc = issue_valid_i && issue_wen_i && issue_rd_i != 0 && !flush_i && !m_stall();
        if (m_stall() && m_stall_cyc != 32'hFFFF_FFFF) m_stall_cyc++;
        if (m_raw() && m_raw_cyc != 32'hFFFF_FFFF) m_raw_cyc++;
        for (int r = 1; r < 32; r++) begin
            if (acc && int'(issue_rd_i) == r) begin
                m_busy[r] = 1; m_left[r] = int'(issue_lat_i);
            end else if (wb_valid_i && int'(wb_rd_i) == r) begin
                m_busy[r] = 0; m_left[r] = 0;
            end else if (m_left[r] > 0) begin
                m_left[r] = m_left[r] - 1;
            end
        end
        m_pend = cnt;
        if (rst_i) begin
            for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_left[r] = 0; end
            m_pend = 0; m_stall_cyc = 0; m_raw_cyc = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rst_i = 0; issue_valid_i = 0; issue_wen_i = 0; issue_rd_i = 0;
        issue_lat_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 0;
        id_use_rs2_i = 0; wb_valid_i = 0; wb_rd_i = 0; flush_i = 0;
    endtask

    task automatic issue(input int rd, input int lat);
        issue_valid_i = 1; issue_wen_i = 1;
        issue_rd_i = 5'(rd); issue_lat_i = 3'(lat);
    endtask

    task automatic test_reset();
        idle(); rst_i = 1; tick(); rst_i = 0; #1;
        n_checks++;
        if (busy_o !== 32'h0 || pending_cnt_o !== 6'd0 || stall_o !== 1'b0)
            $display("FAIL reset_initial: busy=%h pend=%0d stall=%b want 0/0/0",
                     busy_o, pending_cnt_o, stall_o);
        else n_pass++;
        issue(3, 5); tick(); issue(7, 6); tick(); idle(); tick();
        n_checks++;
        if (busy_o !== 32'h0000_0088 || pending_cnt_o !== 6'd2)
            $display("FAIL reset_setup: busy=%h pend=%0d want 00000088/2", busy_o, pending_cnt_o);
        else n_pass++;
        id_rs1_i = 3; id_use_rs1_i = 1; issue(7, 0); rst_i = 1; tick(); idle(); #1;
        n_checks++;
        if (busy_o !== 32'h0 || pending_cnt_o !== 6'd0 || stall_o !== 1'b0)
            $display("FAIL reset_midflight: busy=%h pend=%0d stall=%b want 0/0/0",
                     busy_o, pending_cnt_o, stall_o);
        else n_pass++;
    endtask

    task automatic test_load_use();
        idle(); issue(5, 1); tick(); idle();
        id_rs1_i = 5; id_use_rs1_i = 1; #1;
        n_checks++;
        if (stall_o !== 1'b1) $display("FAIL load_use_stall: stall=%b want 1", stall_o);
        else n_pass++;
        tick();
        n_checks++;
        if (stall_o !== 1'b0 || busy_o[5] !== 1'b1)
            $display("FAIL load_use_release: stall=%b busy5=%b want 0/1", stall_o, busy_o[5]);
        else n_pass++;
        tick();
        n_checks++;
        if (stall_o !== 1'b0 || busy_o[5] !== 1'b1 || pending_cnt_o !== 6'd1)
            $display("FAIL load_use_hold: stall=%b busy5=%b pend=%0d want 0/1/1",
                     stall_o, busy_o[5], pending_cnt_o);
        else n_pass++;
        idle(); wb_valid_i = 1; wb_rd_i = 5; tick(); idle(); tick();
        n_checks++;
        if (busy_o[5] !== 1'b0 || pending_cnt_o !== 6'd0)
            $display("FAIL load_use_wb: busy5=%b pend=%0d want 0/0", busy_o[5], pending_cnt_o);
        else n_pass++;
    endtask

    task automatic test_alu_back_to_back();
        int stalls = 0;
        idle(); issue(6, 0); tick(); idle();
        id_rs2_i = 6; id_use_rs2_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1; if (stall_o !== 1'b0) stalls++;
            tick();
        end
        n_checks++;
        if (stalls != 0 || busy_o[6] !== 1'b1)
            $display("FAIL alu_b2b: stall_cycles=%0d busy6=%b want 0/1", stalls, busy_o[6]);
        else n_pass++;
        idle(); wb_valid_i = 1; wb_rd_i = 6; tick(); idle();
    endtask

    task automatic test_waw();
        int stalls = 0;
        bit done = 0;
        idle(); issue(9, 4); tick(); issue(9, 0);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (stall_o === 1'b1) begin stalls++; tick(); end
            else begin done = 1; tick(); end
        end
        idle();
        n_checks++;
        if (!done || stalls != 4)
            $display("FAIL waw_stall_cycles: got=%0d done=%0d want 4/1", stalls, done);
        else n_pass++;
        id_rs1_i = 9; id_use_rs1_i = 1; #1;
        n_checks++;
        if (busy_o[9] !== 1'b1 || stall_o !== 1'b0)
            $display("FAIL waw_accept: busy9=%b stall=%b want 1/0", busy_o[9], stall_o);
        else n_pass++;
        idle(); wb_valid_i = 1; wb_rd_i = 9; tick(); idle();
    endtask

    task automatic test_x0_flush();
        idle(); issue(0, 3); tick(); idle();
        n_checks++;
        if (busy_o !== 32'h0) $display("FAIL x0_issue: busy=%h want 0", busy_o);
        else n_pass++;
        issue(4, 2); flush_i = 1; tick(); idle();
        n_checks++;
        if (busy_o[4] !== 1'b0) $display("FAIL flush_issue: busy4=%b want 0", busy_o[4]);
        else n_pass++;
        id_rs1_i = 0; id_use_rs1_i = 1; id_rs2_i = 0; id_use_rs2_i = 1; #1;
        n_checks++;
        if (stall_o !== 1'b0) $display("FAIL x0_source: stall=%b want 0", stall_o);
        else n_pass++;
        idle();
    endtask

    task automatic test_same_cycle_issue_wb();
        int stalls = 0;
`ifdef SCOREBOARD_STATS_EN
        logic [31:0] base;
`endif
        idle(); issue(12, 0); tick();
`ifdef SCOREBOARD_STATS_EN
        base = stall_cycles_o;
`endif
        issue(12, 2); wb_valid_i = 1; wb_rd_i = 12; tick(); idle();
        n_checks++;
        if (busy_o[12] !== 1'b1) $display("FAIL issue_wb_same: busy12=%b want 1", busy_o[12]);
        else n_pass++;
        id_rs1_i = 12; id_use_rs1_i = 1;
        for (int i = 0; i < 5; i++) begin
            #1; if (stall_o === 1'b1) stalls++;
            tick();
        end
        n_checks++;
        if (stalls != 2) $display("FAIL issue_wb_cnt: stall_cycles=%0d want 2", stalls);
        else n_pass++;
`ifdef SCOREBOARD_STATS_EN
        n_checks++;
        if (stall_cycles_o - base !== 32'(stalls))
            $display("FAIL stats_delta: got=%0d want %0d", stall_cycles_o - base, stalls);
        else n_pass++;
`endif
        idle(); wb_valid_i = 1; wb_rd_i = 12; tick(); idle();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            rst_i         = ($urandom_range(99) < 2);
            issue_valid_i = ($urandom_range(1) == 1);
            issue_wen_i   = ($urandom_range(9) < 8);
            issue_rd_i    = 5'($urandom_range(7));
            issue_lat_i   = 3'($urandom_range(7));
            id_rs1_i      = 5'($urandom_range(7));
            id_rs2_i      = 5'($urandom_range(7));
            id_use_rs1_i  = ($urandom_range(1) == 1);
            id_use_rs2_i  = ($urandom_range(1) == 1);
            wb_valid_i    = ($urandom_range(9) < 4);
            wb_rd_i       = 5'($urandom_range(7));
            flush_i       = ($urandom_range(9) == 0);
            #1;
            n_checks++;
            if (stall_o !== m_stall() || busy_o !== m_busy_vec() ||
                pending_cnt_o !== 6'(m_pend)) begin
                if (errs < 10)
                    $display("FAIL random_cycle%0d: stall=%b busy=%h pend=%0d want %b/%h/%0d",
                             i, stall_o, busy_o, pending_cnt_o, m_stall(), m_busy_vec(), m_pend);
                errs++;
            end else n_pass++;
`ifdef SCOREBOARD_STATS_EN
            n_checks++;
            if (stall_cycles_o !== m_stall_cyc || raw_stall_cycles_o !== m_raw_cyc)
                $display("FAIL random_stats%0d: stall=%0d raw=%0d want %0d/%0d",
                         i, stall_cycles_o, raw_stall_cycles_o, m_stall_cyc, m_raw_cyc);
            else n_pass++;
`endif
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_left[r] = 0; end
        m_pend = 0; m_stall_cyc = 0; m_raw_cyc = 0;
        @(negedge clk_i);
        test_reset();
        test_load_use();
        test_alu_back_to_back();
        test_waw();
        test_x0_flush();
        test_same_cycle_issue_wb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
